// File: rtl/ps2_scan_sequencer_if.sv
// Decoded-key stream: valid/ready head of the scan-code FIFO.
// Master is the sequencer, slave is the key consumer.
interface ps2_scan_sequencer_if;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;

   modport master (
      output key_valid,
      output key_code,
      output key_ext,
      output key_break,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  key_ext,
      input  key_break,
      output key_ready
   );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into decoded key
// entries and buffers them in a small FIFO with a valid/ready head.
module ps2_scan_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int PREFIX_TMO = 50000000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frm_valid,
   input  logic [10:0]                 frm_data,
   ps2_scan_sequencer_if.master        key,
   output logic                        err_parity,
   output logic                        err_frame,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(PREFIX_TMO + 1);
   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [TW-1:0] TMO_CNT  = PREFIX_TMO[TW-1:0];
   localparam logic [7:0]    PFX_EXT  = 8'hE0;
   localparam logic [7:0]    PFX_BRK  = 8'hF0;

   typedef enum logic [1:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0
   } state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   key_t          mem_q [FIFO_DEPTH];
   key_t          mem_d [FIFO_DEPTH];
   logic          err_parity_q, err_parity_d;
   logic          err_frame_q, err_frame_d;
   logic          overflow_q, overflow_d;

   logic [7:0] rx_byte;
   logic       frame_ok;
   logic       parity_ok;
   logic       timeout;
   logic       push_req;
   logic       push;
   logic       pop;
   logic       full;
   logic       valid;
   key_t       wr_entry;
   key_t       head;

   assign rx_byte   = frm_data[8:1];
   assign frame_ok  = ~frm_data[0] & frm_data[10];
   assign parity_ok = ^frm_data[9:1];
   assign timeout   = (state_q != IDLE) && (tmo_q == TMO_CNT);
   assign full      = (count_q == FULL_CNT);
   assign valid     = (count_q != '0);
   assign pop       = valid & key.key_ready;
   assign push      = push_req & (~full | pop);

   assign wr_entry.ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
   assign wr_entry.brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
   assign wr_entry.code = rx_byte;

   always_comb begin
      state_d      = state_q;
      err_frame_d  = 1'b0;
      err_parity_d = 1'b0;
      push_req     = 1'b0;
      if (frm_valid) begin
         if (!frame_ok) begin
            err_frame_d = 1'b1;
            state_d     = IDLE;
         end else if (!parity_ok) begin
            err_parity_d = 1'b1;
            state_d      = IDLE;
         end else begin
            unique case (1'b1)
               (rx_byte == PFX_EXT): begin
                  err_frame_d = (state_q != IDLE);
                  state_d     = GOT_E0;
               end
               (rx_byte == PFX_BRK): begin
                  case (state_q)
                     IDLE:    state_d = GOT_F0;
                     GOT_E0:  state_d = GOT_E0F0;
                     default: err_frame_d = 1'b1;
                  endcase
               end
               default: begin
                  push_req = 1'b1;
                  state_d  = IDLE;
               end
            endcase
         end
      end else if (timeout) begin
         err_frame_d = 1'b1;
         state_d     = IDLE;
      end
   end

   // Counter only runs while a prefix is pending.
   always_comb begin
      if (state_d == IDLE || frm_valid || timeout) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = push_req & full & ~pop;
      if (push) begin
         mem_d[wr_ptr_q] = wr_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         tmo_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_parity_q <= err_parity_d;
         err_frame_q  <= err_frame_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head          = mem_q[rd_ptr_q];
   assign key.key_valid = valid;
   assign key.key_code  = valid ? head.code : 8'h00;
   assign key.key_ext   = valid & head.ext;
   assign key.key_break = valid & head.brk;

   assign err_parity = err_parity_q;
   assign err_frame  = err_frame_q;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: make/break decoding,
// prefix errors, FIFO overflow, prefix timeout and reset.
module tb_ps2_scan_sequencer;
   localparam int DEPTH = 4;
   localparam int TMO   = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        frm_valid;
   logic [10:0] frm_data;
   logic        err_parity;
   logic        err_frame;
   logic        overflow;
   logic [2:0]  fifo_count;

   int checks  = 0;
   int errors  = 0;
   int ef_cnt  = 0;
   int ovf_cnt = 0;

   ps2_scan_sequencer_if kif ();

   ps2_scan_sequencer #(
      .FIFO_DEPTH(DEPTH),
      .PREFIX_TMO(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frm_valid  (frm_valid),
      .frm_data   (frm_data),
      .key        (kif),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (err_frame) ef_cnt++;
      if (overflow) ovf_cnt++;
   end

   function automatic logic [10:0] mk(input logic [7:0] b,
                                      input logic [2:0] bad);
      // bad: [0] parity, [1] start, [2] stop
      mk = {~bad[2], (~^b) ^ bad[0], b, bad[1]};
   endfunction

   task automatic send(input logic [7:0] b, input logic [2:0] bad,
                       input logic rdy);
      @(negedge clk);
      frm_valid     = 1'b1;
      frm_data      = mk(b, bad);
      kif.key_ready = rdy;
      @(negedge clk);
      frm_valid     = 1'b0;
      kif.key_ready = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      frm_valid     = 1'b1;
      frm_data      = mk(8'h1C, 3'b000);
      kif.key_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL rst_count got %0d want 0", fifo_count);
      end
      checks++;
      if (kif.key_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %b want 0", kif.key_valid);
      end
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h000) begin
         errors++;
         $display("FAIL rst_head got %h want 000",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      checks++;
      if ({err_parity, err_frame, overflow} !== 3'b000) begin
         errors++;
         $display("FAIL rst_err got %b want 000",
                  {err_parity, err_frame, overflow});
      end
      reset         = 1'b0;
      frm_valid     = 1'b0;
      kif.key_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL rst_after got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_make();
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if (kif.key_valid !== 1'b1 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL make_valid got v=%b n=%0d want v=1 n=1",
                  kif.key_valid, fifo_count);
      end
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h01C) begin
         errors++;
         $display("FAIL make_head got %h want 01c",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (kif.key_code !== 8'h1C || kif.key_valid !== 1'b1) begin
         errors++; $display("FAIL make_hold got %h want 1c", kif.key_code);
      end
      pop_one();
      checks++;
      if (fifo_count !== 3'd0 || kif.key_valid !== 1'b0) begin
         errors++; $display("FAIL make_pop got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_ext_break();
      send(8'hE0, 3'b000, 1'b0);
      send(8'hF0, 3'b000, 1'b0);
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL pfx_nopush got %0d want 0", fifo_count);
      end
      send(8'h74, 3'b000, 1'b0);
      checks++;
      if (fifo_count !== 3'd1 ||
          {kif.key_ext, kif.key_break, kif.key_code} !== 10'h374) begin
         errors++;
         $display("FAIL ext_brk got n=%0d %h want n=1 374", fifo_count,
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
      send(8'hF0, 3'b000, 1'b0);
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h11C) begin
         errors++;
         $display("FAIL brk got %h want 11c",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   task automatic test_prefix_errors();
      int e;
      send(8'hF0, 3'b000, 1'b0);
      e = ef_cnt;
      send(8'hE0, 3'b000, 1'b0);
      checks++;
      if (ef_cnt - e !== 1) begin
         errors++; $display("FAIL e0_after_f0 got %0d want 1", ef_cnt - e);
      end
      send(8'h75, 3'b000, 1'b0);
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h275) begin
         errors++;
         $display("FAIL e0_restart got %h want 275",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
      send(8'hF0, 3'b000, 1'b0);
      e = ef_cnt;
      send(8'hF0, 3'b000, 1'b0);
      checks++;
      if (ef_cnt - e !== 1) begin
         errors++; $display("FAIL f0_f0 got %0d want 1", ef_cnt - e);
      end
      send(8'h12, 3'b000, 1'b0);
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h112) begin
         errors++;
         $display("FAIL f0_hold got %h want 112",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   task automatic test_errors();
      send(8'h1C, 3'b001, 1'b0);
      checks++;
      if ({err_parity, err_frame} !== 2'b10 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL parity got pe=%b fe=%b n=%0d want 1 0 0",
                  err_parity, err_frame, fifo_count);
      end
      @(negedge clk);
      checks++;
      if (err_parity !== 1'b0) begin
         errors++; $display("FAIL parity_pulse got %b want 0", err_parity);
      end
      send(8'h1C, 3'b100, 1'b0);
      checks++;
      if ({err_parity, err_frame} !== 2'b01 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL stop got pe=%b fe=%b n=%0d want 0 1 0",
                  err_parity, err_frame, fifo_count);
      end
      send(8'h1C, 3'b010, 1'b0);
      checks++;
      if (err_frame !== 1'b1 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL start got fe=%b n=%0d want 1 0", err_frame,
                  fifo_count);
      end
      send(8'hE0, 3'b000, 1'b0);
      send(8'h33, 3'b001, 1'b0);
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h01C) begin
         errors++;
         $display("FAIL err_abort got %h want 01c",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   task automatic test_overflow();
      int o;
      logic [7:0] exp_q [4];
      exp_q = '{8'h11, 8'h12, 8'h13, 8'h15};
      o = ovf_cnt;
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 3'b000, 1'b0);
      checks++;
      if (fifo_count !== 3'd4 || ovf_cnt - o !== 1) begin
         errors++;
         $display("FAIL ovf_fill got n=%0d ov=%0d want n=4 ov=1",
                  fifo_count, ovf_cnt - o);
      end
      checks++;
      if (kif.key_code !== 8'h10) begin
         errors++; $display("FAIL ovf_head got %h want 10", kif.key_code);
      end
      send(8'h15, 3'b000, 1'b1);
      checks++;
      if (fifo_count !== 3'd4 || ovf_cnt - o !== 1) begin
         errors++;
         $display("FAIL ovf_pushpop got n=%0d ov=%0d want n=4 ov=1",
                  fifo_count, ovf_cnt - o);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (kif.key_code !== exp_q[i]) begin
            errors++;
            $display("FAIL drain%0d got %h want %h", i, kif.key_code,
                     exp_q[i]);
         end
         pop_one();
      end
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL drain_end got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_timeout();
      int e;
      e = ef_cnt;
      send(8'hE0, 3'b000, 1'b0);
      repeat (TMO + 5) @(negedge clk);
      checks++;
      if (ef_cnt - e !== 1) begin
         errors++; $display("FAIL tmo_pulse got %0d want 1", ef_cnt - e);
      end
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h01C) begin
         errors++;
         $display("FAIL tmo_idle got %h want 01c",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
      e = ef_cnt;
      send(8'hE0, 3'b000, 1'b0);
      repeat (10) @(negedge clk);
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if (ef_cnt !== e ||
          {kif.key_ext, kif.key_break, kif.key_code} !== 10'h21C) begin
         errors++;
         $display("FAIL tmo_early got fe=%0d %h want fe=0 21c", ef_cnt - e,
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      frm_valid = 1'b1;
      frm_data  = mk(8'hE0, 3'b000);
      @(negedge clk);
      frm_data  = mk(8'h6B, 3'b000);
      @(negedge clk);
      frm_data  = mk(8'h1C, 3'b000);
      @(negedge clk);
      frm_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd2 ||
          {kif.key_ext, kif.key_break, kif.key_code} !== 10'h26B) begin
         errors++;
         $display("FAIL b2b_first got n=%0d %h want n=2 26b", fifo_count,
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
      checks++;
      if ({kif.key_ext, kif.key_break, kif.key_code} !== 10'h01C) begin
         errors++;
         $display("FAIL b2b_second got %h want 01c",
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   task automatic test_reset_mid();
      send(8'h21, 3'b000, 1'b0);
      send(8'h22, 3'b000, 1'b0);
      send(8'hF0, 3'b000, 1'b0);
      checks++;
      if (fifo_count !== 3'd2) begin
         errors++; $display("FAIL mid_fill got %0d want 2", fifo_count);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (fifo_count !== 3'd0 || kif.key_valid !== 1'b0 ||
          kif.key_code !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst got n=%0d v=%b c=%h want 0 0 00",
                  fifo_count, kif.key_valid, kif.key_code);
      end
      send(8'h1C, 3'b000, 1'b0);
      checks++;
      if (fifo_count !== 3'd1 ||
          {kif.key_ext, kif.key_break, kif.key_code} !== 10'h01C) begin
         errors++;
         $display("FAIL mid_next got n=%0d %h want n=1 01c", fifo_count,
                  {kif.key_ext, kif.key_break, kif.key_code});
      end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_make();
      test_ext_break();
      test_prefix_errors();
      test_errors();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_scan_sequencer.md
PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of decoded-key entries buffered; power of two, range 2..16.
REQ-002 Parameter PREFIX_TMO, default 50000000, maximum clk cycles allowed between a prefix byte and the byte that follows it.
REQ-003 Port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port frm_valid  input  1  one-cycle pulse from the PS/2 receiver marking a complete frame.
REQ-006 Port frm_data  input  11  received frame: bit0 start, bits8:1 data (LSB first), bit9 parity, bit10 stop.
REQ-007 Port key_valid  output  1  FIFO head entry is available.
REQ-008 Port key_ready  input  1  consumer accepts the head entry.
REQ-009 Port key_code  output  8  scan code of the head entry.
REQ-010 Port key_ext  output  1  head entry was preceded by E0 (extended key).
REQ-011 Port key_break  output  1  head entry was preceded by F0 (key release).
REQ-012 Port err_parity  output  1  one-cycle pulse: parity check failed.
REQ-013 Port err_frame  output  1  one-cycle pulse: bad start/stop bit, illegal prefix order, or prefix timeout.
REQ-014 Port overflow  output  1  one-cycle pulse: decoded key dropped because the FIFO was full.
REQ-015 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Function
REQ-016 A frame shall be valid only when frm_valid=1, frm_data[0]=0, frm_data[10]=1, and the XOR of frm_data[9:1] is 1 (odd parity).
REQ-017 Frame with start=1 or stop=0 shall pulse err_frame for one cycle; the frame is dropped and the FSM goes to IDLE.
REQ-018 Frame with good start/stop but bad parity shall pulse err_parity for one cycle; the frame is dropped and the FSM goes to IDLE.
REQ-019 The FSM shall have exactly four states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
REQ-020 On a valid byte, the FSM shall transition as follows:
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0.
- GOT_E0: F0 -> GOT_E0F0.
- Any state: any other byte -> push {ext, brk, code}, then go to IDLE.
- ext=1 in GOT_E0 and GOT_E0F0; brk=1 in GOT_F0 and GOT_E0F0.
REQ-021 E0 received in GOT_E0, GOT_F0 or GOT_E0F0 shall pulse err_frame and go to GOT_E0 (the sequence restarts).
REQ-022 F0 received in GOT_F0 or GOT_E0F0 shall pulse err_frame and leave the state unchanged.
REQ-023 In any non-IDLE state, a cycle counter shall increment every cycle and clear on every frm_valid.
REQ-024 When the counter reaches PREFIX_TMO, the block shall pulse err_frame, clear the counter, and go to IDLE; the counter holds at 0 in IDLE.
REQ-025 A push shall take effect on the clock edge that samples frm_valid; key_valid shall rise on the next cycle (1-cycle latency from frm_valid to key_valid when the FIFO was empty).
REQ-026 key_valid shall equal (fifo_count != 0); key_code, key_ext and key_break shall reflect the head entry and be stable while key_valid=1 and key_ready=0.
REQ-027 A pop shall occur when key_valid and key_ready are both 1 on a clock edge.
REQ-028 A push attempted while full and without a same-cycle pop shall drop the entry and pulse overflow; the FSM still returns to IDLE.
REQ-029 A simultaneous push and pop shall leave fifo_count unchanged, including when the FIFO is full (no overflow).
REQ-030 Read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-031 Error pulses shall be registered, asserting exactly one cycle after the offending frm_valid or timeout event.

Reset
REQ-032 While reset=1, the block shall force: FSM=IDLE, timeout counter=0, FIFO pointers and fifo_count=0, key_valid=0, err_parity=0, err_frame=0, overflow=0.
REQ-033 reset shall override frm_valid and key_ready in the same cycle; any partial prefix sequence and all buffered entries shall be discarded.
REQ-034 key_code, key_ext and key_break shall read 0 after reset.

Verification
REQ-035 Make: frame data 0x1C with good parity -> one cycle later key_valid=1, key_code=0x1C, ext=0, brk=0, fifo_count=1.
REQ-036 Extended break: frames E0, F0, 0x74 -> exactly one entry {ext=1, brk=1, code=0x74}, with no entries pushed for E0 or F0.
REQ-037 Errors: byte 0x1C with flipped parity -> err_parity pulse, no push; frame with stop=0 -> err_frame pulse, no push.
REQ-038 Overflow: 5 valid makes with key_ready=0 (depth 4) -> fifo_count=4, one overflow pulse; a 6th make arriving with key_ready=1 on a full FIFO -> no overflow, count stays 4.
REQ-039 Timeout: E0 then idle for PREFIX_TMO cycles -> err_frame pulse; a following 0x1C is pushed with ext=0.
REQ-040 Reset mid-operation: reset asserted while in GOT_F0 with 2 entries buffered -> fifo_count=0, key_valid=0; a next 0x1C is pushed with brk=0.
